// File: rtl/vixen_mem_pkg.sv
// Shared types and default geometry for the vixen CPU/video RAM arbiter.
package vixen_mem_pkg;

   localparam int VIXEN_AW          = 16;
   localparam int VIXEN_DW          = 16;
   localparam int VIXEN_MAX_VID_RUN = 4;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_VID = 1'b1
   } owner_t;

endpackage

// File: rtl/vixen_mem_arb_grant.sv
// Combinational priority decision: video first, CPU forced through after a bounded video run.
// Zero latency; at most one grant, and only to a requester that is valid.
module vixen_mem_arb_grant
   import vixen_mem_pkg::*;
#(
   parameter int MAX_VID_RUN = VIXEN_MAX_VID_RUN
) (
   input  logic       cpu_valid,
   input  logic       vid_valid,
   input  state_t     state,
   input  logic [3:0] run_cnt,
   output logic       grant_cpu,
   output logic       grant_vid
);

   localparam logic [3:0] MAX_RUN = 4'(MAX_VID_RUN);

   always_comb begin
      grant_cpu = 1'b0;
      grant_vid = 1'b0;
      if (state == LOCKED) begin
         grant_cpu = cpu_valid;
      end else if (vid_valid && !(cpu_valid && run_cnt == MAX_RUN)) begin
         grant_vid = 1'b1;
      end else begin
         grant_cpu = cpu_valid;
      end
   end

endmodule

// File: rtl/vixen_mem_arbiter.sv
// Single-port RAM arbiter for vixen CPU and video scanout; grants combinational, read data one cycle later.
// Optional stall/lock statistics ports are enabled by VIXEN_MEM_ARB_STATS_EN.
module vixen_mem_arbiter
   import vixen_mem_pkg::*;
#(
   parameter int AW          = VIXEN_AW,
   parameter int DW          = VIXEN_DW,
   parameter int MAX_VID_RUN = VIXEN_MAX_VID_RUN
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_valid,
   output logic          cpu_ready,
   input  logic          cpu_we,
   input  logic          cpu_lock,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          vid_valid,
   output logic          vid_ready,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_rvalid,
   output logic [DW-1:0] vid_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef VIXEN_MEM_ARB_STATS_EN
   ,
   output logic [15:0]   cpu_stall_cnt,
   output logic [15:0]   vid_stall_cnt,
   output logic [15:0]   lock_cycles
`endif
);

   localparam logic [3:0] MAX_RUN = 4'(MAX_VID_RUN);

   state_t     state, state_nxt;
   logic [3:0] run_cnt, run_cnt_nxt;
   logic       grant_cpu_raw, grant_vid_raw;
   logic       grant_cpu, grant_vid;
   logic       rd_pend;
   owner_t     rd_owner;

   vixen_mem_arb_grant #(.MAX_VID_RUN(MAX_VID_RUN)) u_grant (
      .cpu_valid (cpu_valid),
      .vid_valid (vid_valid),
      .state     (state),
      .run_cnt   (run_cnt),
      .grant_cpu (grant_cpu_raw),
      .grant_vid (grant_vid_raw)
   );

   // Grants are combinational, so reset must mask them to keep the RAM idle.
   assign grant_cpu = grant_cpu_raw & rst_n;
   assign grant_vid = grant_vid_raw & rst_n;
   assign cpu_ready = grant_cpu;
   assign vid_ready = grant_vid;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_cpu) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (grant_vid) begin
         mem_en    = 1'b1;
         mem_addr  = vid_addr;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB:     if (grant_cpu && cpu_lock) state_nxt = LOCKED;
         // A dropped, unlocked request also releases the bus so video cannot hang.
         LOCKED:  if ((grant_cpu && !cpu_lock) || (!cpu_valid && !cpu_lock)) state_nxt = ARB;
         default: state_nxt = ARB;
      endcase
   end

   always_comb begin
      run_cnt_nxt = run_cnt;
      if (grant_cpu || !cpu_valid) begin
         run_cnt_nxt = '0;
      end else if (grant_vid && run_cnt != MAX_RUN) begin
         run_cnt_nxt = run_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ARB;
         run_cnt  <= '0;
         rd_pend  <= 1'b0;
         rd_owner <= OWN_CPU;
      end else begin
         state    <= state_nxt;
         run_cnt  <= run_cnt_nxt;
         rd_pend  <= (grant_cpu && !cpu_we) || grant_vid;
         rd_owner <= grant_vid ? OWN_VID : OWN_CPU;
      end
   end

   // Gating by rst_n drops a response whose access was granted just before reset.
   assign cpu_rvalid = rst_n & rd_pend & (rd_owner == OWN_CPU);
   assign vid_rvalid = rst_n & rd_pend & (rd_owner == OWN_VID);
   assign cpu_rdata  = mem_rdata;
   assign vid_rdata  = mem_rdata;

`ifdef VIXEN_MEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cpu_stall_cnt <= '0;
         vid_stall_cnt <= '0;
         lock_cycles   <= '0;
      end else begin
         if (cpu_valid && !cpu_ready && cpu_stall_cnt != 16'hFFFF)
            cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
         if (vid_valid && !vid_ready && vid_stall_cnt != 16'hFFFF)
            vid_stall_cnt <= vid_stall_cnt + 16'd1;
         if (state == LOCKED && lock_cycles != 16'hFFFF)
            lock_cycles <= lock_cycles + 16'd1;
      end
   end
`endif

endmodule
